// File: rtl/commit_release_arbiter_pkg.sv
// Shared sizing and state encoding for the commit release arbiter.
`timescale 1ns/1ps
package commit_release_arbiter_pkg;
  localparam int NUM_UNITS   = 8;
  localparam int WIDTH_UNITS = $clog2(NUM_UNITS);

  typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_WAIT} commit_arb_state_t;
endpackage

// File: rtl/commit_release_arbiter_if.sv
// Release/ack/commit bundle between the port-map release outputs and the commit unit.
`timescale 1ns/1ps
interface commit_release_arbiter_if
  import commit_release_arbiter_pkg::*;
#(
  parameter int N = NUM_UNITS
);
  logic [N-1:0] I_Release;
  logic [N-1:0] I_Ack;
  logic         I_Full;
  logic [N-1:0] O_Commit;
  logic [N-1:0] O_Pending;
  logic         O_Busy;
  logic         O_Overrun;
  logic         O_Error;

  modport slave (
    input  I_Release, I_Ack, I_Full,
    output O_Commit, O_Pending, O_Busy, O_Overrun, O_Error
  );

  modport master (
    output I_Release, I_Ack, I_Full,
    input  O_Commit, O_Pending, O_Busy, O_Overrun, O_Error
  );
endinterface

// File: rtl/commit_release_arbiter_rr_pick.sv
// Rotating priority pick: first set request at or after i_ptr, modulo N; zero latency, no state.
`timescale 1ns/1ps
module commit_release_arbiter_rr_pick #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_ptr,
  output logic [N-1:0] o_grt,
  output logic         o_valid
);
  int w_best;
  int w_dist;

  // Circular distance from the pointer; the smallest distance wins, so no power-of-2 N is needed.
  always_comb begin
    o_grt  = '0;
    w_best = N;
    w_dist = 0;
    for (int i = 0; i < N; i++) begin
      w_dist = (i >= int'(i_ptr)) ? (i - int'(i_ptr)) : (i + N - int'(i_ptr));
      if (i_req[i] && (w_dist < w_best)) begin
        w_best   = w_dist;
        o_grt    = '0;
        o_grt[i] = 1'b1;
      end
    end
  end

  assign o_valid = |i_req;
endmodule

// File: rtl/commit_release_arbiter.sv
// Serialises per-unit release pulses into one-hot commit strobes, round-robin, ack-or-retry per grant.
// Release-to-strobe two cycles; I_Full stalls only new grants, an issued grant always acks or drops.
`timescale 1ns/1ps
module commit_release_arbiter
  import commit_release_arbiter_pkg::*;
#(
  parameter int NUM_UNITS   = commit_release_arbiter_pkg::NUM_UNITS,
  parameter int WIDTH_UNITS = $clog2(NUM_UNITS),
  parameter int TIMEOUT_CYC = 15,
  parameter int MAX_RETRY   = 3
) (
  input  logic                         clock,
  input  logic                         reset,
  commit_release_arbiter_if.slave      bus
);
  commit_arb_state_t      r_state, w_state_nxt;
  logic [NUM_UNITS-1:0]   r_pending, w_pending_nxt;
  logic [NUM_UNITS-1:0]   r_grant, w_grant_nxt;
  logic [NUM_UNITS-1:0]   w_pick, w_clr;
  logic [WIDTH_UNITS-1:0] r_ptr, w_ptr_nxt, w_gidx, w_ptr_inc;
  logic [7:0]             r_timer, w_timer_nxt;
  logic [2:0]             r_retry, w_retry_nxt;
  logic                   r_overrun, w_overrun_nxt;
  logic                   r_error, w_error_nxt;
  logic                   w_pick_vld, w_ack_hit, w_timeout;

  commit_release_arbiter_rr_pick #(.N(NUM_UNITS), .W(WIDTH_UNITS)) u_pick (
    .i_req   (r_pending),
    .i_ptr   (r_ptr),
    .o_grt   (w_pick),
    .o_valid (w_pick_vld)
  );

  always_comb begin
    w_gidx = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (r_grant[i]) w_gidx = WIDTH_UNITS'(i);
    end
  end

  assign w_ptr_inc = (w_gidx == WIDTH_UNITS'(NUM_UNITS - 1)) ? '0 : w_gidx + 1'b1;
  assign w_ack_hit = (r_state == ARB_WAIT) && |(bus.I_Ack & r_grant);
  assign w_timeout = (r_state == ARB_WAIT) && !w_ack_hit && (r_timer == 8'(TIMEOUT_CYC - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_ptr_nxt   = r_ptr;
    w_timer_nxt = r_timer;
    w_retry_nxt = r_retry;
    w_error_nxt = r_error;
    w_clr       = '0;
    case (r_state)
      ARB_IDLE: begin
        if (w_pick_vld && !bus.I_Full) begin
          w_grant_nxt = w_pick;
          w_state_nxt = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        w_timer_nxt = '0;
        w_state_nxt = ARB_WAIT;
      end
      ARB_WAIT: begin
        w_timer_nxt = r_timer + 8'd1;
        if (w_ack_hit) begin
          w_clr       = r_grant;
          w_ptr_nxt   = w_ptr_inc;
          w_grant_nxt = '0;
          w_retry_nxt = '0;
          w_state_nxt = ARB_IDLE;
        end else if (w_timeout) begin
          if (r_retry < 3'(MAX_RETRY)) begin
            w_retry_nxt = r_retry + 3'd1;
            w_state_nxt = ARB_ISSUE;
          end else begin
            w_clr       = r_grant;
            w_error_nxt = 1'b1;
            w_ptr_nxt   = w_ptr_inc;
            w_grant_nxt = '0;
            w_retry_nxt = '0;
            w_state_nxt = ARB_IDLE;
          end
        end
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  // Set wins over clear, so a release landing on its own ack edge is never lost.
  assign w_pending_nxt = (r_pending & ~w_clr) | bus.I_Release;
  assign w_overrun_nxt = r_overrun | (|(bus.I_Release & r_pending & ~w_clr));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= ARB_IDLE;
      r_pending <= '0;
      r_grant   <= '0;
      r_ptr     <= '0;
      r_timer   <= '0;
      r_retry   <= '0;
      r_overrun <= 1'b0;
      r_error   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pending <= w_pending_nxt;
      r_grant   <= w_grant_nxt;
      r_ptr     <= w_ptr_nxt;
      r_timer   <= w_timer_nxt;
      r_retry   <= w_retry_nxt;
      r_overrun <= w_overrun_nxt;
      r_error   <= w_error_nxt;
    end
  end

  assign bus.O_Commit  = (r_state == ARB_ISSUE) ? r_grant : '0;
  assign bus.O_Pending = r_pending;
  assign bus.O_Busy    = (r_state != ARB_IDLE) || (|r_pending);
  assign bus.O_Overrun = r_overrun;
  assign bus.O_Error   = r_error;
endmodule
